uncache_axi_bridge: RTL and testbench
=====================================

// Module: uncache_axi_bridge
// PURPOSE
//  Data-side uncached access path, directly downstream of the fixed-map address translator.
//  Takes the CPU SRAM-like request that carries the translated physical address and the
//  data_uncached flag, and turns each accepted access into exactly one single-beat AXI3/4
//  read or write. Only one access is outstanding at a time (strongly ordered, as MMIO requires).
//  Cached accesses (uncached=0) are ignored here; the dcache serves them.
// PARAMETERS
//  AXI_ID  default 4'd1  constant ARID/AWID/WID value driven by the crossbar wrapper (not ported)
// PORTS
//  clk       in   1   single clock for all logic
//  resetn    in   1   asynchronous, active-low reset
//  req       in   1   CPU access request
//  uncached  in   1   translator data_uncached; a request is taken only when req&&uncached
//  wr        in   1   1=write, 0=read
//  size      in   2   0=byte, 1=half, 2=word; 3 is treated as 2
//  addr      in   32  physical address (`INST_ADDR_BUS), already translated
//  wdata     in   32  write data, lane-aligned
//  wstrb     in   4   byte enables for writes
//  addr_ok   out  1   request accepted this cycle
//  data_ok   out  1   one-cycle completion pulse
//  rdata     out  32  read data; valid while data_ok=1 and held until the next accepted read
//  araddr/arsize/arvalid  out 32/3/1  AR channel;  arready in 1
//  rdata_axi in 32, rvalid in 1, rlast in 1, rresp in 2;  rready out 1
//  awaddr/awsize/awvalid  out 32/3/1  AW channel;  awready in 1
//  wdata_axi out 32, wstrb_axi out 4, wvalid out 1, wlast out 1 (tied 1);  wready in 1
//  bvalid in 1, bresp in 2;  bready out 1
//  LEN=0, BURST=INCR, LOCK/CACHE/PROT=0 are constants at the crossbar wrapper and are not ported.
// BEHAVIOUR
//  Reset: state=IDLE. All valids, readies, addr_ok and data_ok are 0; rdata=0.
//  FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B.
//  IDLE
//   - addr_ok = req&&uncached (combinational; only in IDLE).
//   - On acceptance, latch addr, size, wdata, wstrb and wr.
//   - Next state: RD_AR if wr=0, else WR_AWW.
//  RD_AR
//   - arvalid=1 with the latched addr/size; hold it stable until arready.
//   - On the handshake -> RD_R.
//  RD_R
//   - rready=1.
//   - On rvalid: register rdata_axi into rdata, pulse data_ok the next cycle, -> IDLE.
//  WR_AWW
//   - awvalid and wvalid both rise on entry. Flags aw_done and w_done record each handshake.
//   - Each valid drops individually after its own handshake.
//   - Either channel may complete first or both in the same cycle.
//   - When both are done -> WR_B.
//  WR_B
//   - bready=1.
//   - On bvalid: pulse data_ok the next cycle, -> IDLE.
//  Latency, zero-wait slave:
//   - read: accept at T0; AR at T1; R at T2; data_ok at T3.
//   - write: accept at T0; AW/W at T1; B at T2; data_ok at T3.
//  The IDLE cycle that carries data_ok may also raise addr_ok: back-to-back access with no
//  bubble beyond the FSM.
//  arsize/awsize = {1'b0, size==3 ? 2'd2 : size}. The address is passed unaligned (narrow transfer).
//  rresp/bresp are ignored: an error completes like OKAY, and SLVERR data is returned as-is.
//  rlast is ignored because LEN=0.
//  Request inputs are don't-care outside IDLE; the CPU holds req until addr_ok.
//  Reset mid-operation: all channel valids drop immediately and the FSM returns to IDLE.
//  The interconnect is reset by the same resetn, so no transaction is left dangling.
// STRUCTURE
//  - State encodings and AXI size/burst constants go in shared defines.v (`UC_IDLE.., `AXI_BURST_INCR).
//  - One sub-module is natural: uncache_req_latch, the request capture register with a
//    size->axsize map.
//  - The FSM and channel handshakes stay in this module.
// TESTING
//  1. req,uncached,rd,addr=0x1faf_f000,size=2; arready held off 3 cycles, rdata_axi=0x1234_5678
//     -> araddr=0x1faf_f000, arsize=2; data_ok one cycle after R; rdata=0x1234_5678.
//  2. Write addr=0x1faf_f010, wdata=0xdead_beef, wstrb=4'b0011, size=1; wready 2 cycles before awready
//     -> wvalid drops after its own handshake; awvalid held; bready only in WR_B;
//        data_ok one cycle after B.
//  3. req=1, uncached=0 -> addr_ok=0; no AR or AW valid for 10 cycles.
//  4. Back-to-back read, write, read with zero-wait slave -> data_ok at T3, T6, T9;
//     addr_ok in the same cycle as each prior data_ok.
//  5. size=3, byte read addr=0x1faf_f003 -> arsize=2 for the first;
//     a byte read gives arsize=0, araddr=0x1faf_f003.
//  6. resetn low during RD_R, then high -> arvalid/rready/data_ok=0 immediately;
//     a new request is accepted in the first cycle after release.
//  7. bresp=2'b10 -> completes normally; data_ok pulses once.

Source files
------------

// File: rtl/uncache_axi_bridge_pkg.sv
// Shared constants and types for the uncached AXI bridge: FSM encodings,
// fixed AXI attributes and the captured-request record.
package uncache_axi_bridge_pkg;

    // Fixed AXI attributes driven by the crossbar wrapper
    localparam logic [3:0] AXI_ID         = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // FSM state encodings
    localparam logic [2:0] UC_IDLE   = 3'd0;
    localparam logic [2:0] UC_RD_AR  = 3'd1;
    localparam logic [2:0] UC_RD_R   = 3'd2;
    localparam logic [2:0] UC_WR_AWW = 3'd3;
    localparam logic [2:0] UC_WR_B   = 3'd4;

    // One captured CPU access. Direction is not stored here because the
    // FSM branch taken at acceptance already records it.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  axsize;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } uc_req_t;

    // CPU size code to AXI AxSIZE; code 3 is treated as a word access.
    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, (size == 2'd3) ? 2'd2 : size};
    endfunction

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// Single-beat AXI channel bundle between the uncached bridge (master) and
// the interconnect (slave). Constant attributes are not carried here.
interface uncache_axi_bridge_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata_axi;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata_axi;
    logic [3:0]  wstrb_axi;
    logic        wvalid;
    logic        wlast;
    logic        wready;

    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid,
        output wdata_axi, wstrb_axi, wvalid, wlast, bready,
        input  arready, rdata_axi, rvalid, rlast, rresp,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid,
        input  wdata_axi, wstrb_axi, wvalid, wlast, bready,
        output arready, rdata_axi, rvalid, rlast, rresp,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/uncache_axi_bridge_req_latch.sv
// Request capture register: holds address, AXI size, write data and byte
// enables of the accepted access for the whole AXI transaction.
module uncache_axi_bridge_req_latch
    import uncache_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output uc_req_t     q
);

    // Capture the request on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: these are plain data registers, but they are reset anyway so the
        // AXI address/data outputs never show X after reset.
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignment for all clocked state so every
            // register samples pre-edge values regardless of block order.
            q <= '{addr: addr, axsize: size_to_axsize(size), wdata: wdata, wstrb: wstrb};
        end
    end

endmodule

// File: rtl/uncache_axi_bridge.sv
// Uncached data-side bridge: turns each accepted CPU SRAM-like access with
// uncached=1 into one single-beat AXI read or write, one access at a time.
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        req,
    input  logic                        uncached,
    input  logic                        wr,
    input  logic [1:0]                  size,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wstrb,
    output logic                        addr_ok,
    output logic                        data_ok,
    output logic [31:0]                 rdata,
    uncache_axi_bridge_if.master        axi
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       aw_done;
    logic       w_done;
    uc_req_t    cur;

    logic accept;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic r_done;
    logic b_done;
    logic unused_resp;

    assign accept  = (state == UC_IDLE) && req && uncached;
    assign addr_ok = accept;

    assign ar_hs  = axi.arvalid && axi.arready;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign r_done = (state == UC_RD_R) && axi.rvalid;
    assign b_done = (state == UC_WR_B) && axi.bvalid;

    // Responses are completed regardless of status; rlast is implied by LEN=0
    assign unused_resp = ^{axi.rresp, axi.bresp, axi.rlast};

    uncache_axi_bridge_req_latch u_req_latch (
        .clk    (clk),
        .resetn (resetn),
        .load   (accept),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .q      (cur)
    );

    // Channel outputs are decoded from state so reset drops them at once
    assign axi.araddr    = cur.addr;
    assign axi.arsize    = cur.axsize;
    assign axi.arvalid   = (state == UC_RD_AR);
    assign axi.rready    = (state == UC_RD_R);
    assign axi.awaddr    = cur.addr;
    assign axi.awsize    = cur.axsize;
    assign axi.awvalid   = (state == UC_WR_AWW) && !aw_done;
    assign axi.wdata_axi = cur.wdata;
    assign axi.wstrb_axi = cur.wstrb;
    assign axi.wvalid    = (state == UC_WR_AWW) && !w_done;
    assign axi.wlast     = 1'b1;
    assign axi.bready    = (state == UC_WR_B);

    // Next-state logic; the IDLE branch records the access direction
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            UC_IDLE:   if (accept) state_nxt = wr ? UC_WR_AWW : UC_RD_AR;
            UC_RD_AR:  if (ar_hs) state_nxt = UC_RD_R;
            UC_RD_R:   if (axi.rvalid) state_nxt = UC_IDLE;
            UC_WR_AWW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = UC_WR_B;
            UC_WR_B:   if (axi.bvalid) state_nxt = UC_IDLE;
            default:   state_nxt = UC_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= UC_IDLE;
        else         state <= state_nxt;
    end

    // Per-channel completion flags for the AW/W phase, cleared on leaving it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state_nxt != UC_WR_AWW) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Completion pulse one cycle after the R or B handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data_ok <= 1'b0;
        else         data_ok <= r_done || b_done;
    end

    // Read data register, held until the next read returns
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rdata <= '0;
        else if (r_done) rdata <= axi.rdata_axi;
    end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Scoreboard bench for uncache_axi_bridge: stimulus pushes expected AXI
// beats and completions into queues, a monitor pops and compares them.
module tb_uncache_axi_bridge;
    import uncache_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        uncached = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    uncache_axi_bridge_if axi ();

    uncache_axi_bridge dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .uncached (uncached),
        .wr       (wr),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .addr_ok  (addr_ok),
        .data_ok  (data_ok),
        .rdata    (rdata),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Slave configuration
    int          ar_delay = 0;
    int          aw_delay = 0;
    int          w_delay = 0;
    int          r_delay = 0;
    logic [31:0] r_value = '0;
    logic [1:0]  b_resp_cfg = 2'b00;

    // Scoreboard queues
    typedef struct { logic [31:0] addr; logic [2:0] size; } a_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
    typedef struct { bit is_read; logic [31:0] rdata; int due; } d_exp_t;
    a_exp_t exp_ar[$];
    a_exp_t exp_aw[$];
    w_exp_t exp_w[$];
    d_exp_t exp_done[$];

    // AXI slave model: decisions at negedge, handshakes retired one negedge later
    initial begin
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
        bit ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
        bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata_axi = '0; axi.rlast = 0; axi.rresp = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
                ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            end else begin
                if (ar_fire) begin axi.arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
                if (r_fire)  axi.rvalid = 0;
                if (aw_fire) begin axi.awready = 0; aw_cnt = 0; aw_got = 1; end
                if (w_fire)  begin axi.wready = 0; w_cnt = 0; w_got = 1; end
                if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
                if (b_fire)  axi.bvalid = 0;

                if (axi.arvalid && !axi.arready) begin
                    if (ar_cnt >= ar_delay) axi.arready = 1; else ar_cnt++;
                end
                if (axi.awvalid && !axi.awready) begin
                    if (aw_cnt >= aw_delay) axi.awready = 1; else aw_cnt++;
                end
                if (axi.wvalid && !axi.wready) begin
                    if (w_cnt >= w_delay) axi.wready = 1; else w_cnt++;
                end
                if (r_pend && !axi.rvalid) begin
                    if (r_cnt >= r_delay) begin
                        axi.rvalid = 1; axi.rdata_axi = r_value; axi.rlast = 1; axi.rresp = 0;
                        r_pend = 0;
                    end else r_cnt++;
                end
                if (b_pend && !axi.bvalid) begin
                    axi.bvalid = 1; axi.bresp = b_resp_cfg; b_pend = 0;
                end

                ar_fire = axi.arvalid && axi.arready;
                r_fire  = axi.rvalid && axi.rready;
                aw_fire = axi.awvalid && axi.awready;
                w_fire  = axi.wvalid && axi.wready;
                b_fire  = axi.bvalid && axi.bready;
            end
        end
    end

    // Monitor: compares handshakes and completions against the queues
    initial begin
        bit prev_dok = 0, w_seen = 0, aw_seen = 0;
        a_exp_t a;
        w_exp_t w;
        d_exp_t d;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                prev_dok = 0; w_seen = 0; aw_seen = 0;
            end else begin
                if (axi.arvalid) check("rready_in_ar", axi.rready, 1'b0);
                if (axi.awvalid || axi.wvalid) check("bready_in_aww", axi.bready, 1'b0);
                if (w_seen) check("wvalid_drop", axi.wvalid, 1'b0);
                if (w_seen && !aw_seen) check("awvalid_held", axi.awvalid, 1'b1);
                if (axi.arvalid && axi.arready) begin
                    if (exp_ar.size() == 0) check("unexpected_ar", 1, 0);
                    else begin
                        a = exp_ar.pop_front();
                        check("araddr", axi.araddr, a.addr);
                        check("arsize", {29'd0, axi.arsize}, {29'd0, a.size});
                    end
                end
                if (axi.awvalid && axi.awready) begin
                    if (exp_aw.size() == 0) check("unexpected_aw", 1, 0);
                    else begin
                        a = exp_aw.pop_front();
                        check("awaddr", axi.awaddr, a.addr);
                        check("awsize", {29'd0, axi.awsize}, {29'd0, a.size});
                    end
                    aw_seen = 1;
                end
                if (axi.wvalid && axi.wready) begin
                    if (exp_w.size() == 0) check("unexpected_w", 1, 0);
                    else begin
                        w = exp_w.pop_front();
                        check("wdata", axi.wdata_axi, w.data);
                        check("wstrb", {28'd0, axi.wstrb_axi}, {28'd0, w.strb});
                        check("wlast", axi.wlast, 1'b1);
                    end
                    w_seen = 1;
                end
                if (data_ok) begin
                    check("data_ok_single_pulse", prev_dok, 1'b0);
                    if (exp_done.size() == 0) check("unexpected_data_ok", 1, 0);
                    else begin
                        d = exp_done.pop_front();
                        if (d.is_read) check("rdata", rdata, d.rdata);
                        if (d.due >= 0) check("data_ok_cycle", cyc, d.due);
                    end
                    w_seen = 0; aw_seen = 0;
                end
                prev_dok = data_ok;
            end
        end
    end

    // Issue one access (entered and left at a negedge); t0 = acceptance cycle
    task automatic cpu_req(input bit is_wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd_val,
                           input logic [2:0] exp_axsize, input int lat, output int t0);
        bit got = 0;
        req = 1; uncached = 1; wr = is_wr; size = sz; addr = a; wdata = wd; wstrb = ws;
        t0 = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (addr_ok) begin
                got = 1;
                t0 = cyc;
                if (is_wr) begin
                    exp_aw.push_back('{a, exp_axsize});
                    exp_w.push_back('{wd, ws});
                end else begin
                    exp_ar.push_back('{a, exp_axsize});
                    r_value = rd_val;
                end
                exp_done.push_back('{!is_wr, rd_val, (lat < 0) ? -1 : t0 + lat});
            end
            @(negedge clk);
        end
        req = 0; uncached = 0;
        if (!got) check("addr_ok_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_done.size() != 0; i++) @(negedge clk);
        check("completion_drain", exp_done.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, ta, tb, tc, rel;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_addr_ok", addr_ok, 1'b0);
        check("rst_data_ok", data_ok, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);

        // 1: word read, arready held off 3 cycles
        ar_delay = 3;
        cpu_req(0, 2'd2, 32'h1faf_f000, '0, '0, 32'h1234_5678, 3'd2, 6, t0);
        wait_done();
        ar_delay = 0;

        // 2: half write, W accepted before AW
        aw_delay = 2;
        cpu_req(1, 2'd1, 32'h1faf_f010, 32'hdead_beef, 4'b0011, '0, 3'd1, 5, t0);
        wait_done();
        aw_delay = 0;

        // 3: cached request is ignored
        req = 1; uncached = 0; wr = 0; addr = 32'h1faf_f000; size = 2'd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("cached_addr_ok", addr_ok, 1'b0);
            check("cached_no_valid", {axi.arvalid, axi.awvalid}, 2'b00);
            @(negedge clk);
        end
        req = 0;

        // 4: back-to-back read, write, read with zero-wait slave
        cpu_req(0, 2'd2, 32'h1faf_f020, '0, '0, 32'ha5a5_0001, 3'd2, 3, ta);
        cpu_req(1, 2'd2, 32'h1faf_f024, 32'h0bad_f00d, 4'hf, '0, 3'd2, 3, tb);
        cpu_req(0, 2'd2, 32'h1faf_f028, '0, '0, 32'h5a5a_0002, 3'd2, 3, tc);
        check("b2b_accept_2", tb, ta + 3);
        check("b2b_accept_3", tc, ta + 6);
        wait_done();

        // 5: size code 3 maps to word; byte read keeps unaligned address
        cpu_req(0, 2'd3, 32'h1faf_f000, '0, '0, 32'h0bcd_ef01, 3'd2, 3, t0);
        cpu_req(0, 2'd0, 32'h1faf_f003, '0, '0, 32'h0000_0077, 3'd0, 3, t0);
        wait_done();

        // 6: reset while waiting in RD_R
        r_delay = 4;
        cpu_req(0, 2'd2, 32'h1faf_f030, '0, '0, 32'hcafe_0000, 3'd2, -1, t0);
        repeat (2) @(negedge clk);
        #1;
        check("in_rd_r_rready", axi.rready, 1'b1);
        resetn = 0;
        #1;
        check("midrst_arvalid", axi.arvalid, 1'b0);
        check("midrst_rready", axi.rready, 1'b0);
        check("midrst_data_ok", data_ok, 1'b0);
        check("midrst_rdata", rdata, 32'h0);
        exp_done.delete();
        repeat (2) @(negedge clk);
        r_delay = 0;
        resetn = 1;
        rel = cyc;
        cpu_req(0, 2'd2, 32'h1faf_f034, '0, '0, 32'h600d_0006, 3'd2, 3, t0);
        check("accept_after_release", t0, rel);
        wait_done();

        // 7: SLVERR write response completes normally
        b_resp_cfg = 2'b10;
        cpu_req(1, 2'd2, 32'h1faf_f040, 32'h1357_9bdf, 4'hf, '0, 3'd2, 3, t0);
        wait_done();
        b_resp_cfg = 2'b00;
        repeat (5) @(negedge clk);

        check("ar_queue_empty", exp_ar.size(), 0);
        check("aw_queue_empty", exp_aw.size(), 0);
        check("w_queue_empty", exp_w.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
